// File: rtl/snake_pixel_render.sv
// Per-pixel RGB565 colour generator for the snake game: border, head/food/body
// layers, an IDLE/PLAY/OVER game FSM and a frame-counted game-over blink.
module snake_pixel_render #(
  parameter int H_DISP       = 800,
  parameter int V_DISP       = 600,
  parameter int BLOCK_W      = 10,
  parameter int SIDE_W       = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        game_start,
  input  logic        game_over,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  input  logic [9:0]  food_x,
  input  logic [9:0]  food_y,
  input  logic        body_hit,
  output logic [15:0] pixel_data,
  output logic [1:0]  game_state
);

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_q, blink_d;
  logic [15:0]      pix_q, pix_d;

  logic        frame_tick;
  logic        in_disp;
  logic        on_border;
  logic        st_play;
  logic        st_over;
  logic [11:0] x12, y12;
  logic [9:0]  sq_x [2];
  logic [9:0]  sq_y [2];
  logic [1:0]  sq_hit;

  assign frame_tick = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
  assign in_disp    = (pixel_xpos < 11'(H_DISP)) && (pixel_ypos < 11'(V_DISP));
  assign on_border  = (pixel_xpos < 11'(SIDE_W)) || (pixel_xpos >= 11'(H_DISP - SIDE_W)) ||
                      (pixel_ypos < 11'(SIDE_W)) || (pixel_ypos >= 11'(V_DISP - SIDE_W));

  // Code 3 is neither PLAY nor OVER, so it behaves exactly like IDLE.
  assign st_play = (state_q == ST_PLAY);
  assign st_over = (state_q == ST_OVER);

  assign x12 = {1'b0, pixel_xpos};
  assign y12 = {1'b0, pixel_ypos};

  assign sq_x[0] = head_x;
  assign sq_y[0] = head_y;
  assign sq_x[1] = food_x;
  assign sq_y[1] = food_y;

  // 12-bit edges so a square near column 1023 extends past the field instead of wrapping.
  for (genvar gi = 0; gi < 2; gi++) begin : g_square
    logic [11:0] x_lo, x_hi, y_lo, y_hi;
    assign x_lo = {2'b00, sq_x[gi]};
    assign y_lo = {2'b00, sq_y[gi]};
    assign x_hi = x_lo + 12'(BLOCK_W);
    assign y_hi = y_lo + 12'(BLOCK_W);
    assign sq_hit[gi] = (x12 >= x_lo) && (x12 < x_hi) && (y12 >= y_lo) && (y12 < y_hi);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLAY: if (game_over)  state_d = ST_OVER;
      ST_OVER: if (game_start) state_d = ST_IDLE;
      default: if (game_start) state_d = ST_PLAY;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (st_play && game_over) begin
      frame_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (st_over && frame_tick) begin
      if (frame_cnt_q == CNT_MAX) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    pix_d = WHITE;
    if (!in_disp)                pix_d = BLACK;
    else if (on_border)          pix_d = BLUE;
    else if (!st_play && !st_over) pix_d = BLACK;
    else if (st_over && blink_q) pix_d = RED;
    else if (sq_hit[0])          pix_d = BLUE;
    else if (sq_hit[1])          pix_d = GREEN;
    else if (body_hit)           pix_d = RED;
    else                         pix_d = WHITE;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      pix_q       <= BLACK;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      pix_q       <= pix_d;
    end
  end

  assign pixel_data = pix_q;
  assign game_state = state_q;

endmodule
